// File: rtl/multicycle_controller_if.sv
//-----------------------------------------------------------------------------
// multicycle_controller_if
//   Bundle between the multicycle controller and the ARM datapath.
//   master : controller side (consumes IR contents and ALU flags, drives the
//            datapath enables and mux selects, exposes Flags/State for debug)
//   slave  : datapath side (the mirror image)
//   Signals:
//     Instr      IR contents: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12]
//     ALUFlags   NZCV from the ALU in the current cycle
//     PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//     ALUControl, ImmSrc, RegSrc, RegWrite   datapath controls
//     Flags      registered NZCV
//     State      current FSM state code
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

interface multicycle_controller_if #(
    parameter int ALUCTL_W = 3
);
    logic [31:0]         Instr;
    logic [3:0]          ALUFlags;
    logic                PCWrite;
    logic                AdrSrc;
    logic                MemWrite;
    logic                IRWrite;
    logic [1:0]          ResultSrc;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [ALUCTL_W-1:0] ALUControl;
    logic [1:0]          ImmSrc;
    logic [1:0]          RegSrc;
    logic                RegWrite;
    logic [3:0]          Flags;
    logic [3:0]          State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State
    );
endinterface

// File: rtl/multicycle_controller.sv
//-----------------------------------------------------------------------------
// multicycle_controller
//   Moore FSM plus instruction decoder sequencing the multicycle ARM datapath
//   (shared memory, IR/data registers, ALU reused for PC+4). Holds the NZCV
//   condition flags and the per-instruction condition-pass bit.
//   Ports:
//     clk    clock, all state updates on the rising edge
//     reset  asynchronous, active-low reset
//     bus    multicycle_controller_if.master (decode inputs, datapath controls)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   FETCH  | read instruction at PC into IR, PC <= PC+4
//   DECODE | read registers, evaluate condition, ALU forms PC+8
//   MEMADR | ALU forms base +/- imm12 memory address
//   MEMRD  | read data memory at ALUOut
//   MEMWB  | write loaded data to Rd (or PC)
//   MEMWR  | write RD2 to data memory at ALUOut
//   EXECR  | data-processing with register operand
//   EXECI  | data-processing with immediate operand
//   ALUWB  | write ALU result to Rd (or PC)
//   BRANCH | PC <= PC+8 + imm24
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module multicycle_controller #(
    parameter int         ALUCTL_W  = 3,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_instr_bits;

    assign cond  = bus.Instr[31:28];
    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign rd    = bus.Instr[15:12];
    assign cmd   = funct[4:1];
    assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

    // Data-processing decode
    logic [2:0] dp_alu;
    logic       dp_supported;
    logic       dp_arith;
    logic       dp_cmp;

    always_comb begin
        dp_alu       = ALU_ADD;
        dp_supported = 1'b1;
        dp_arith     = 1'b0;
        dp_cmp       = 1'b0;
        unique case (cmd)
            4'b0100: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
            4'b1010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; dp_cmp = 1'b1; end
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            default: dp_supported = 1'b0;
        endcase
    end

    // Condition check against the registered flags
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        unique case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // State, flags and condition-pass registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            flags_q  <= FLAGS_RST;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    // Next state
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Condition pass is captured once per instruction, at the end of DECODE
    assign condex_d = (state_q == S_DECODE) ? cond_pass : condex_q;

    // N,Z follow any supported op; C,V only come from the adder/subtractor
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && condex_q &&
            dp_supported && (funct[0] || dp_cmp)) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (dp_arith)
                flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    // Moore outputs
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src;
    logic [2:0] alu_ctl;
    logic       dp_writeback;

    assign dp_writeback = condex_q & dp_supported & ~dp_cmp;

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        result_src = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctl    = ALU_ADD;
        imm_src    = op;
        reg_src    = {(op == 2'b01) & ~funct[0], (op == 2'b10)};

        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                alu_ctl   = funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                // A load into R15 is a jump through Result
                if (rd == 4'd15) pc_write  = condex_q;
                else             reg_write = condex_q;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = condex_q;
            end
            S_EXECR: begin
                alu_src_b = 2'b00;
                alu_ctl   = dp_alu;
            end
            S_EXECI: begin
                alu_src_b = 2'b01;
                alu_ctl   = dp_alu;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                if (rd == 4'd15) pc_write  = dp_writeback;
                else             reg_write = dp_writeback;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = condex_q;
            end
            default: ;
        endcase

        // Reset forces every enable and select low immediately
        if (!reset) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            result_src = 2'b00;
            alu_src_b  = 2'b00;
            alu_ctl    = ALU_ADD;
            imm_src    = 2'b00;
            reg_src    = 2'b00;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = ALUCTL_W'(alu_ctl);
    assign bus.ImmSrc     = imm_src;
    assign bus.RegSrc     = reg_src;
    assign bus.RegWrite   = reg_write;
    assign bus.Flags      = flags_q;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps

module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    multicycle_controller_if #(.ALUCTL_W(3)) bus ();

    multicycle_controller #(.ALUCTL_W(3), .FLAGS_RST(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] mflags;
    logic       fix_en;
    logic [3:0] fix_af;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] observed_ctrl();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc,
                bus.RegWrite};
    endfunction

    // ARM condition: even code = base predicate, odd code = its inverse
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            default: base = ~z & (n == v);
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic bit is_supported(input logic [3:0] cmd);
        return cmd == 4'h4 || cmd == 4'h2 || cmd == 4'hA || cmd == 4'h0 || cmd == 4'hC;
    endfunction

    // Expected control vector for a given state code of an instruction
    function automatic logic [16:0] exp_ctrl(input int st, input logic [31:0] ins, input logic pass);
        logic       pcw, adr, memw, irw, srca, regw;
        logic [1:0] ress, srcb, imms, regs;
        logic [2:0] aluc;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd;
        bit         wb;
        op = ins[27:26]; fn = ins[25:20]; cmd = fn[4:1];
        {pcw, adr, memw, irw, srca, regw} = '0;
        ress = 0; srcb = 0; aluc = 0;
        imms = op;
        regs = {op == 2'b01 && !fn[0], op == 2'b10};
        case (cmd)
            4'h2, 4'hA: aluc = 3'd1;
            4'h0:       aluc = 3'd2;
            4'hC:       aluc = 3'd3;
            default:    aluc = 3'd0;
        endcase
        if (st != 6 && st != 7) aluc = 3'd0;
        case (st)
            0: begin irw = 1; pcw = 1; srca = 1; srcb = 2; ress = 2; end
            1: begin srca = 1; srcb = 2; ress = 2; end
            2: begin srcb = 1; aluc = fn[3] ? 3'd0 : 3'd1; end
            3: adr = 1;
            4: begin
                ress = 1;
                if (ins[15:12] == 4'hF) pcw = pass; else regw = pass;
            end
            5: begin adr = 1; memw = pass; end
            6: srcb = 0;
            7: srcb = 1;
            8: begin
                wb = pass && is_supported(cmd) && cmd != 4'hA;
                if (ins[15:12] == 4'hF) pcw = wb; else regw = wb;
            end
            9: begin srcb = 1; ress = 2; pcw = pass; end
            default: ;
        endcase
        return {pcw, adr, memw, irw, ress, srca, srcb, aluc, imms, regs, regw};
    endfunction

    // Runs one instruction from FETCH entry; caller sits at posedge+1.
    // abort_at >= 0 stops just before that step (left in that state).
    task automatic run_instr(input logic [31:0] ins, input int abort_at);
        int         seq[$];
        logic       pass;
        logic [3:0] af;
        logic [3:0] cmd;
        cmd  = ins[24:21];
        pass = cond_ok(ins[31:28], mflags);
        seq  = {0, 1};
        case (ins[27:26])
            2'b00: begin seq.push_back(ins[25] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (ins[20]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        for (int k = 0; k < seq.size(); k++) begin
            if (k == abort_at) return;
            af = fix_en ? fix_af : 4'($urandom_range(0, 15));
            bus.Instr    = ins;
            bus.ALUFlags = af;
            #1;
            chk($sformatf("state ins=%h step=%0d", ins, k), 32'(bus.State), 32'(seq[k]));
            chk($sformatf("ctrl ins=%h state=%0d", ins, seq[k]), 32'(observed_ctrl()),
                32'(exp_ctrl(seq[k], ins, pass)));
            chk($sformatf("flags ins=%h step=%0d", ins, k), 32'(bus.Flags), 32'(mflags));
            if ((seq[k] == 6 || seq[k] == 7) && pass && is_supported(cmd) &&
                (ins[20] || cmd == 4'hA)) begin
                mflags[3:2] = af[3:2];
                if (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'hA) mflags[1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] sup_cmd [5];
    logic [31:0] rnd;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mflags  = 4'b0000;
        fix_en  = 1'b0;
        fix_af  = 4'b0000;
        sup_cmd = '{4'h4, 4'h2, 4'hA, 4'h0, 4'hC};
        reset        = 1'b0;
        bus.Instr    = 32'hE080_2001;
        bus.ALUFlags = 4'b0000;

        #2;
        chk("reset state", 32'(bus.State), 32'd0);
        chk("reset ctrl", 32'(observed_ctrl()), 32'd0);
        chk("reset flags", 32'(bus.Flags), 32'd0);

        @(posedge clk); #1;
        reset = 1'b1;

        // Directed instructions
        run_instr(32'hE080_2001, -1);            // ADD R2,R0,R1
        run_instr(32'hE590_2008, -1);            // LDR
        run_instr(32'hE580_2004, -1);            // STR
        run_instr(32'hEA00_0001, -1);            // B
        fix_en = 1'b1; fix_af = 4'b0100;
        run_instr(32'hE050_0000, -1);            // SUBS -> Z
        chk("flags after SUBS", 32'(bus.Flags), 32'h4);
        run_instr(32'h1080_2001, -1);            // ADDNE, fails
        fix_af = 4'b1001;
        run_instr(32'hE150_0001, -1);            // CMP
        chk("flags after CMP", 32'(bus.Flags), 32'h9);
        fix_en = 1'b0;
        run_instr(32'hE080_F001, -1);            // ADD PC,...
        run_instr(32'hEC00_0000, -1);            // Op=11

        // Reset mid-EXECR
        run_instr(32'hE080_2001, 2);
        chk("pre-reset in EXECR", 32'(bus.State), 32'd6);
        #2;
        reset = 1'b0;
        #1;
        mflags = 4'b0000;
        chk("mid reset state", 32'(bus.State), 32'd0);
        chk("mid reset ctrl", 32'(observed_ctrl()), 32'd0);
        chk("mid reset flags", 32'(bus.Flags), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("release state", 32'(bus.State), 32'd0);
        chk("release IRWrite", 32'(bus.IRWrite), 32'd1);
        chk("release PCWrite", 32'(bus.PCWrite), 32'd1);

        // Randomised instruction stream
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            if ($urandom_range(0, 3) != 0) rnd[24:21] = sup_cmd[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) rnd[15:12] = 4'hF;
            if ($urandom_range(0, 1) == 0) rnd[31:28] = 4'hE;
            run_instr(rnd, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
